// File: rtl/alu_arbiter.sv
// Two-requester arbiter that serialises operations onto one shared ALU, one operation in flight.
// Latency SETTLE+1 cycles from acceptance to rsp_valid; both requesters stall until the response handshakes.
module alu_arbiter #(
  parameter int SETTLE = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0_valid,
  input  logic [3:0]  req0_cmd,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [3:0]  req1_cmd,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        req1_ready,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_cmd,
  output logic        alu_oe,
  input  logic [15:0] alu_d,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [15:0] rsp_data,
  input  logic        rsp_ready
);

  typedef enum logic [1:0] {IDLE, DRIVE, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        last_grant_q, last_grant_d;
  logic        id_q, id_d;
  logic        oe_q, oe_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [3:0]  cmd_q, cmd_d;
  logic [7:0]  a_q, a_d;
  logic [7:0]  b_q, b_d;
  logic [15:0] data_q, data_d;
  logic        grant0, grant1;

  // Under contention the requester that was not served last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      grant0 = req0_valid & (~req1_valid | last_grant_q);
      grant1 = req1_valid & (~req0_valid | ~last_grant_q);
    end
  end

  // Gated with resetn so no grant is visible while reset is held.
  assign req0_ready = grant0 & resetn;
  assign req1_ready = grant1 & resetn;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    oe_d         = oe_q;
    rsp_valid_d  = rsp_valid_q;
    cmd_d        = cmd_q;
    a_d          = a_q;
    b_d          = b_q;
    data_d       = data_q;
    case (state_q)
      IDLE: begin
        if (grant0 | grant1) begin
          id_d    = grant1;
          cmd_d   = grant1 ? req1_cmd : req0_cmd;
          a_d     = grant1 ? req1_a   : req0_a;
          b_d     = grant1 ? req1_b   : req0_b;
          cnt_d   = 2'd0;
          oe_d    = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == 2'(SETTLE - 1)) begin
          data_d      = alu_d;
          oe_d        = 1'b0;
          rsp_valid_d = 1'b1;
          cnt_d       = 2'd0;
          state_d     = RESP;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d  = 1'b0;
          last_grant_d = id_q;
          state_d      = IDLE;
        end
      end
      default: begin
        oe_d        = 1'b0;
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q      <= IDLE;
      cnt_q        <= 2'd0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      oe_q         <= 1'b0;
      rsp_valid_q  <= 1'b0;
      cmd_q        <= 4'd0;
      a_q          <= 8'd0;
      b_q          <= 8'd0;
      data_q       <= 16'd0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      oe_q         <= oe_d;
      rsp_valid_q  <= rsp_valid_d;
      cmd_q        <= cmd_d;
      a_q          <= a_d;
      b_q          <= b_d;
      data_q       <= data_d;
    end
  end

  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_cmd   = cmd_q;
  assign alu_oe    = oe_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = id_q;
  assign rsp_data  = data_q;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter SETTLE, default 1, legal 1..3: cycles the ALU inputs are held with alu_oe high before alu_d is captured.
REQ-002 The block SHALL have port clock, input, 1: sole clock; all state updates on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1: reset, asynchronous, active-low.
REQ-004 The block SHALL have ports req0_valid input 1 and req1_valid input 1: requester N presents an operation.
REQ-005 The block SHALL have ports req0_cmd/req1_cmd input 4: ALU command code 0000..1111, passed through unchecked.
REQ-006 The block SHALL have ports req0_a/req1_a input 8 and req0_b/req1_b input 8: operands.
REQ-007 The block SHALL have ports req0_ready/req1_ready output 1: grant; the request is accepted in the cycle where valid and ready are both high.
REQ-008 The block SHALL have ports alu_a output 8, alu_b output 8 and alu_cmd output 4: drive the shared ALU's a_in, b_in and command_in.
REQ-009 The block SHALL have port alu_oe, output, 1: drives the ALU output enable.
REQ-010 The block SHALL have port alu_d, input, 16: ALU result; it is valid only while alu_oe is high.
REQ-011 The block SHALL have ports rsp_valid output 1, rsp_id output 1 (0=req0, 1=req1) and rsp_data output 16: result channel.
REQ-012 The block SHALL have port rsp_ready, input, 1: consumer accepts the result.

Function
REQ-013 The block SHALL implement FSM states IDLE, DRIVE, RESP, with one operation in flight at most.
REQ-014 In IDLE the block SHALL assert exactly one reqN_ready, combinationally from the valids and a last_grant register: only one valid -> that requester; both valid -> the requester not equal to last_grant; none valid -> both ready low.
REQ-015 On acceptance the block SHALL latch cmd, a, b and id into internal registers and move to DRIVE on the next edge.
REQ-016 alu_a, alu_b and alu_cmd SHALL always be driven from the latched registers and SHALL change only on acceptance.
REQ-017 In DRIVE the block SHALL hold alu_oe high, count SETTLE cycles, capture alu_d into rsp_data on the last of them, then enter RESP.
REQ-018 alu_oe SHALL be low in IDLE and RESP.
REQ-019 In RESP the block SHALL hold rsp_valid high with rsp_data/rsp_id stable until rsp_valid and rsp_ready are both high, then update last_grant to rsp_id and return to IDLE.
REQ-020 Both reqN_ready SHALL be low in DRIVE and RESP; requesters hold valid/cmd/a/b stable until accepted.
REQ-021 Latency SHALL be fixed: acceptance at edge T gives rsp_valid high from edge T+SETTLE+1. With rsp_ready held high, the next acceptance occurs in the cycle after the response handshake, so throughput is one operation per SETTLE+2 cycles.
REQ-022 A single requester held valid SHALL be served back-to-back; arbitration fairness applies only while both requesters are valid.
REQ-023 The block SHALL apply no interpretation of cmd or result: rsp_data equals the captured alu_d bit-for-bit, including 16'hFFFF for divide by zero.

Reset
REQ-024 While resetn is low the block SHALL immediately force: state IDLE, reqN_ready 0, alu_oe 0, alu_a/alu_b/alu_cmd 0, rsp_valid 0, rsp_id 0, rsp_data 0, last_grant 1 (so req0 wins the first contention), settle counter 0.
REQ-025 Reset asserted mid-operation (DRIVE or RESP) SHALL abort the operation: the block produces no response for it after release and the requester is not re-served unless it re-presents.
REQ-026 After resetn deasserts the block SHALL accept a request at the first rising edge.

Verification
REQ-027 Bench SHALL cover reset: resetn low for 3 cycles with both valids high -> all outputs 0, no ready asserted.
REQ-028 Bench SHALL cover single op, SETTLE=1: req0 ADD a=8'h12 b=8'h34 accepted at T -> alu_oe high for one cycle, rsp_valid at T+2, rsp_id 0, rsp_data 16'h0046.
REQ-029 Bench SHALL cover contention: both valid from reset, req0 MUL 8'h03*8'h05 and req1 AND 8'hF0&8'h3C, each re-presenting after service -> grant order 0,1,0,1; responses 16'h000F (id 0) and 16'h0030 (id 1) alternate.
REQ-030 Bench SHALL cover backpressure: rsp_ready low for 5 cycles in RESP -> rsp_valid/rsp_data/rsp_id stable, both reqN_ready low, alu_oe low; the handshake on the 6th cycle returns the FSM to IDLE.
REQ-031 Bench SHALL cover abort: resetn pulsed low during DRIVE -> alu_oe low asynchronously, no rsp_valid after release, and next accept at the first edge.
REQ-032 Bench SHALL cover divide by zero with SETTLE=3: req1 DIV a=8'h20 b=8'h00 -> alu_oe high 3 cycles, rsp_data 16'hFFFF at T+4, rsp_id 1.
